// File: rtl/packet_gate_pkg.sv
// rtl/packet_gate_pkg.sv - shared encodings and helpers for the packet gate
package packet_gate_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_DECISION = 2'd0,
        ST_FORWARD       = 2'd1,
        ST_DROP          = 2'd2
    } gate_state_e;

    localparam logic DECISION_FORWARD = 1'b1;
    localparam logic DECISION_DROP    = 1'b0;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == COUNT_MAX) ? v : v + 32'd1;
    endfunction

    function automatic gate_state_e decision_target(input logic d);
        case (d)
            DECISION_FORWARD: return ST_FORWARD;
            DECISION_DROP:    return ST_DROP;
            default:          return ST_DROP;
        endcase
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - show-ahead FIFO, head word visible while not empty
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_COUNT   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_COUNT = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS:0] ONE_COUNT    = (MAX_DEPTH_BITS+1)'(1);
    localparam logic [MAX_DEPTH_BITS-1:0] ONE_PTR    = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (count_q != FULL_COUNT);
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = do_wr ? wr_ptr_q + ONE_PTR : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + ONE_PTR : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + ONE_COUNT;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - ONE_COUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not flushed; pointers alone define the valid contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout        = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= NEARLY_COUNT);

endmodule

// File: rtl/packet_gate.sv
// rtl/packet_gate.sv - buffers packets and forwards or drops each one per decision bit
module packet_gate
    import packet_gate_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_FIFO_DEPTH_BITS  = 8
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              decision_dout,
    input  logic                              decision_empty,
    output logic                              decision_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [31:0]                       pass_count,
    output logic [31:0]                       drop_count
);

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W = DW + UW + SW + 1;

    logic [FIFO_W-1:0] fifo_din, fifo_dout;
    logic              fifo_wr, fifo_rd, fifo_empty, fifo_nearly_full;
    logic              head_last;

    gate_state_e state_q, state_d;
    logic [31:0] pass_count_q, pass_count_d;
    logic [31:0] drop_count_q, drop_count_d;

    assign fifo_din = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    assign fifo_wr  = s_axis_tvalid && s_axis_tready;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (axi_aclk),
        .reset       (axi_areset),
        .din         (fifo_din),
        .wr_en       (fifo_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign s_axis_tready = !fifo_nearly_full && !axi_areset;
    assign m_axis_tdata  = fifo_dout[DW-1:0];
    assign m_axis_tstrb  = fifo_dout[DW+SW-1:DW];
    assign m_axis_tuser  = fifo_dout[DW+SW+UW-1:DW+SW];
    assign m_axis_tlast  = fifo_dout[FIFO_W-1];
    assign head_last     = fifo_dout[FIFO_W-1];

    // Outputs are gated by reset so a flush never exposes a stale head or pops a decision.
    always_comb begin
        state_d        = state_q;
        pass_count_d   = pass_count_q;
        drop_count_d   = drop_count_q;
        decision_rd_en = 1'b0;
        m_axis_tvalid  = 1'b0;
        fifo_rd        = 1'b0;
        if (!axi_areset) begin
            unique case (state_q)
                ST_WAIT_DECISION: begin
                    if (!decision_empty && !fifo_empty) begin
                        decision_rd_en = 1'b1;
                        state_d        = decision_target(decision_dout);
                    end
                end
                ST_FORWARD: begin
                    m_axis_tvalid = !fifo_empty;
                    if (!fifo_empty && m_axis_tready) begin
                        fifo_rd = 1'b1;
                        if (head_last) begin
                            pass_count_d = sat_inc(pass_count_q);
                            state_d      = ST_WAIT_DECISION;
                        end
                    end
                end
                ST_DROP: begin
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        if (head_last) begin
                            drop_count_d = sat_inc(drop_count_q);
                            state_d      = ST_WAIT_DECISION;
                        end
                    end
                end
                default: state_d = ST_WAIT_DECISION;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= ST_WAIT_DECISION;
            pass_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pass_count_q <= pass_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pass_count = pass_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_packet_gate.sv
// tb/tb_packet_gate.sv - randomized self-checking bench for packet_gate
module tb_packet_gate;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic          decision_dout, decision_empty, decision_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]   pass_count, drop_count;

    always #5 axi_aclk = ~axi_aclk;

    packet_gate dut (
        .axi_aclk       (axi_aclk),
        .axi_areset     (axi_areset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .decision_dout  (decision_dout),
        .decision_empty (decision_empty),
        .decision_rd_en (decision_rd_en),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .pass_count     (pass_count),
        .drop_count     (drop_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t       in_q[$];
    beat_t       exp_q[$];
    bit          dec_q[$];
    beat_t       held;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_pass = 0;
    logic [31:0] exp_drop = 0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    int          cyc = 0;
    int          pops, fires, saw_valid, pop_cyc, first_fire, last_fire;
    bit          hold_m = 0;
    bit          s_hold = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic clear_stats();
        pops = 0; fires = 0; saw_valid = 0;
        pop_cyc = -1; first_fire = -1; last_fire = -1;
    endtask

    // Reference model: a forwarded packet appears intact and in order, a dropped one never appears.
    task automatic add_packet(input int len, input bit fwd, input bit push_dec);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom();
            for (int w = 0; w < UW/32; w++) b.user[w*32 +: 32] = $urandom();
            b.strb = $urandom();
            b.last = (i == len - 1);
            in_q.push_back(b);
            if (fwd) exp_q.push_back(b);
        end
        if (fwd) exp_pass = sat1(exp_pass);
        else     exp_drop = sat1(exp_drop);
        if (push_dec) dec_q.push_back(fwd);
    endtask

    task automatic step();
        beat_t e;
        bit    acc, popd;
        @(negedge axi_aclk);
        if (!s_hold) s_axis_tvalid = (in_q.size() != 0) && ($urandom_range(99) < valid_pct);
        if (s_axis_tvalid) begin
            s_axis_tdata = in_q[0].data;
            s_axis_tstrb = in_q[0].strb;
            s_axis_tuser = in_q[0].user;
            s_axis_tlast = in_q[0].last;
        end
        m_axis_tready  = ($urandom_range(99) < ready_pct);
        decision_empty = (dec_q.size() == 0);
        decision_dout  = decision_empty ? 1'($urandom()) : dec_q[0];
        #1;
        if (m_axis_tvalid) saw_valid++;
        if (hold_m) begin
            chk("hold_valid", DW'(m_axis_tvalid), DW'(1));
            chk("hold_data", m_axis_tdata, held.data);
            chk("hold_user", DW'(m_axis_tuser), DW'(held.user));
            chk("hold_last", DW'(m_axis_tlast), DW'(held.last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", DW'(1), DW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", m_axis_tdata, e.data);
                chk("out_strb", DW'(m_axis_tstrb), DW'(e.strb));
                chk("out_user", DW'(m_axis_tuser), DW'(e.user));
                chk("out_last", DW'(m_axis_tlast), DW'(e.last));
            end
            fires++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        hold_m = m_axis_tvalid && !m_axis_tready;
        if (hold_m) begin
            held.data = m_axis_tdata;
            held.user = m_axis_tuser;
            held.last = m_axis_tlast;
        end
        popd = decision_rd_en;
        if (popd) begin
            if (dec_q.size() == 0) chk("pop_when_empty", DW'(1), DW'(0));
            pops++;
            pop_cyc = cyc;
        end
        acc    = s_axis_tvalid && s_axis_tready;
        s_hold = s_axis_tvalid && !s_axis_tready;
        @(posedge axi_aclk);
        if (acc && in_q.size() != 0) void'(in_q.pop_front());
        if (popd && dec_q.size() != 0) void'(dec_q.pop_front());
        cyc++;
    endtask

    task automatic drain(input int extra);
        int guard = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0 || dec_q.size() != 0) && guard < 3000) begin
            step();
            guard++;
        end
        chk("drain_in_time", DW'(guard < 3000), DW'(1));
        repeat (extra) step();
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pass"}, DW'(pass_count), DW'(exp_pass));
        chk({tag, "_drop"}, DW'(drop_count), DW'(exp_drop));
    endtask

    task automatic reset_dut(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge axi_aclk);
            axi_areset    = 1'b1;
            s_axis_tvalid = 1'b0;
            #1;
            chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
            chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
            chk("rst_rd_en", DW'(decision_rd_en), DW'(0));
            @(posedge axi_aclk);
        end
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        in_q.delete(); exp_q.delete(); dec_q.delete();
        exp_pass = 0; exp_drop = 0;
        hold_m = 0; s_hold = 0;
        decision_empty = 1'b1;
        #1;
        chk("post_rst_pass", DW'(pass_count), DW'(0));
        chk("post_rst_drop", DW'(drop_count), DW'(0));
        chk("post_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("post_rst_rd_en", DW'(decision_rd_en), DW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        axi_areset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b0; decision_empty = 1'b1; decision_dout = 1'b0;
        reset_dut(3);

        clear_stats();
        add_packet(3, 1'b1, 1'b1);
        drain(4);
        chk_counts("fwd3");
        chk("fwd3_pops", DW'(pops), DW'(1));
        chk("fwd3_beats", DW'(fires), DW'(3));
        chk("fwd3_b2b", DW'(last_fire - first_fire), DW'(2));
        chk("fwd3_latency", DW'(first_fire > pop_cyc), DW'(1));

        clear_stats();
        add_packet(4, 1'b0, 1'b1);
        drain(8);
        chk("drop4_no_valid", DW'(saw_valid), DW'(0));
        chk("drop4_pops", DW'(pops), DW'(1));
        chk_counts("drop4");

        clear_stats();
        add_packet(5, 1'b1, 1'b0);
        repeat (20) step();
        chk("late_no_valid", DW'(saw_valid), DW'(0));
        chk("late_no_pop", DW'(pops), DW'(0));
        dec_q.push_back(1'b1);
        drain(4);
        chk("late_beats", DW'(fires), DW'(5));
        chk_counts("late");

        clear_stats();
        ready_pct = 50;
        add_packet(1, 1'b1, 1'b1);
        add_packet(2, 1'b0, 1'b1);
        add_packet(5, 1'b1, 1'b1);
        drain(8);
        chk("mix_beats", DW'(fires), DW'(6));
        chk("mix_pops", DW'(pops), DW'(3));
        chk_counts("mix");

        clear_stats();
        ready_pct = 100;
        add_packet(4, 1'b1, 1'b1);
        g = 0;
        while (fires < 2 && g < 100) begin
            step();
            g++;
        end
        chk("midrst_reached", DW'(fires), DW'(2));
        reset_dut(1);
        clear_stats();
        add_packet(2, 1'b0, 1'b1);
        add_packet(3, 1'b1, 1'b1);
        drain(6);
        chk("midrst_beats", DW'(fires), DW'(3));
        chk_counts("midrst");

        for (int r = 0; r < 4; r++) begin
            ready_pct = $urandom_range(30, 100);
            valid_pct = $urandom_range(40, 100);
            for (int p = 0; p < 10; p++) add_packet($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b1);
            drain(10);
            chk_counts("rand");
        end

        ready_pct = 100;
        valid_pct = 100;
        @(negedge axi_aclk);
        force dut.pass_count_q = 32'hFFFF_FFFE;
        @(posedge axi_aclk);
        #1;
        release dut.pass_count_q;
        exp_pass = 32'hFFFF_FFFE;
        for (int p = 0; p < 3; p++) add_packet(p + 1, 1'b1, 1'b1);
        drain(6);
        chk_counts("sat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
